omp_estimate_c: RTL and testbench
=================================

Name: omp_estimate_c

Overview:
- Block C of the OMP reconstruction pipeline: final image estimation once Block A has chosen the support set.
- Computes b = Q^T·y over the selected K columns, then solves U·x = b by back-substitution (U upper-triangular from QR).
- Streams out a 64-pixel image: x_k at pixel lambda[k], zero elsewhere.
- Reads Q, y and U from external synchronous BRAMs.

Parameters:
- DW, 24: fixed-point word width, signed Q10.13 (1.0 = 24'h002000).
- FRAC, 13: fractional bits.
- LANES, 4: elements per 96-bit BRAM word; lane 0 = bits[23:0].
- K_MAX, 16: maximum support size.
- N_PIX, 64: image pixels.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start_c  in  1  one-cycle start pulse.
- K_final  in  5  support size, 0..16; values above 16 are clamped to 16.
- M_limit  in  3  last y word index; measurements = 4·(M_limit+1).
- lambda_in  in  6  support pixel index.
- lambda_idx  in  4  support slot k.
- lambda_we  in  1  write lambda_in into slot lambda_idx; honoured only when idle.
- q_addr  out  7  Q BRAM address: k·8 + m_word. Column-major, 8 words per column.
- q_rdata  in  96  4 lanes of Q[4·m_word+l, k].
- y_addr  out  3  y BRAM word address.
- y_data  in  96  4 lanes of y.
- u_addr  out  6  U BRAM address: j·4 + (i>>2). U[i,j] is in lane i%4.
- u_rdata  in  96  U column data.
- pixel_addr  out  6  output pixel index.
- pixel_val  out  24  output pixel value.
- pixel_we  out  1  pixel write strobe.
- block_c_done  out  1  one-cycle completion pulse.

Behaviour:
- Reset: all outputs 0, FSM to IDLE, lambda registers and x/b registers cleared.
- BRAMs have 1-cycle read latency: data corresponds to the address driven on the previous cycle. The block must pipeline or wait accordingly.
- FSM states: IDLE -> PROJ -> BSUB -> PIXEL -> DONE -> IDLE.
- IDLE: accept lambda_we writes. On start_c go to PROJ. start_c in any other state is ignored.
- PROJ: for k = 0..K-1 and m_word = 0..M_limit:
  - read q_addr = k·8+m_word and y_addr = m_word;
  - accumulate the sum of 4 lane products, each 48-bit product arithmetic-shifted right by FRAC;
  - use a ≥32-bit accumulator, saturated to 24 bits when stored as b_k.
- BSUB: for i = K-1 down to 0, x_i = (b_i − Σ_{j>i} U[i,j]·x_j) / U[i,i].
  - U[i,j] is read at u_addr = j·4+(i>>2), lane i%4.
  - Products are shifted right by FRAC.
  - Division uses the fxp_div sub-module: numerator pre-shifted left by FRAC; result truncated toward zero and saturated to 24 bits.
  - U[i,i] = 0 gives x_i = 0.
- PIXEL: emit p = 0..63 on consecutive cycles with pixel_we=1.
  - pixel_val = x_k if lambda[k] == p for some k < K, otherwise 0.
  - Duplicate lambda entries: the lowest k wins.
- DONE: block_c_done high for exactly 1 cycle after pixel 63; pixel_we low. Then IDLE.
- K_final = 0: PROJ and BSUB are skipped; 64 zero pixels are written, then done.
- Lambda slots ≥ K_final are ignored.
- Async reset mid-operation aborts immediately. No pixel or done is emitted afterwards.
- Latency bound: ≤ K·(M_limit+1)·2 + K²·2 + K·(DW+FRAC+4) + 70 cycles.

Decomposition:
- Shared package omp_pkg:
  - DW, FRAC, LANES, K_MAX, N_PIX;
  - FSM state typedef;
  - fixed-point multiply-shift and saturate functions.
- One sub-module fxp_div: sequential signed restoring divider, (DW+FRAC)-bit dividend, start/done handshake.

Test Plan:
- Nominal case, setup:
  - lambda = {4, 10, 39}, K_final=3, M_limit=0;
  - y word 0 = {0,0,0,1.0}; Q words 0/8/16 lane0 = 9.0 / 16.0 / 8.0;
  - U addr0 = {…,2.0}; addr4 lanes = {1.0, 3.0}; addr8 lanes = {1.0, 2.0, 4.0}.
  - Required response: 64 writes; pixel 4 = 24'h003000 (1.5), pixel 10 = 24'h008000 (4), pixel 39 = 24'h004000 (2), others 0; one done pulse.
- K_final=0 -> 64 zero pixels then block_c_done, no BSUB reads.
- M_limit=7, y all 1.0, Q column 0 lane0 = 1.0 in all 8 words, U[0,0]=1.0, K=1, lambda0=0 -> pixel 0 = 8.0 (24'h010000).
- U[0,0]=0, K=1 -> pixel lambda0 = 0; no hang; done still asserted.
- rst_n pulled low during PIXEL -> outputs 0 immediately. A restart produces the full correct 64-pixel frame.
- start_c and lambda_we asserted while busy -> ignored; results unchanged.

Source files
------------

// File: rtl/omp_pkg.sv
// Shared definitions for the OMP estimation block: widths, FSM states and
// Q10.13 fixed-point multiply / saturate helpers.
package omp_pkg;

  localparam int DW    = 24;
  localparam int FRAC  = 13;
  localparam int LANES = 4;
  localparam int K_MAX = 16;
  localparam int N_PIX = 64;
  localparam int NUM_W = DW + FRAC;
  localparam int ACC_W = 2 * DW;

  localparam logic signed [DW-1:0]    SAT_POS = 24'sh7FFFFF;
  localparam logic signed [DW-1:0]    SAT_NEG = 24'sh800000;
  localparam logic signed [ACC_W-1:0] ACC_POS = 48'sh0000_007F_FFFF;
  localparam logic signed [ACC_W-1:0] ACC_NEG = -48'sh0000_0080_0000;
  localparam logic [NUM_W-1:0]        MAG_POS = NUM_W'(24'h7FFFFF);
  localparam logic [NUM_W-1:0]        MAG_NEG = NUM_W'(24'h800000);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PROJ  = 3'd1,
    ST_BSUB  = 3'd2,
    ST_PIXEL = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  function automatic logic signed [ACC_W-1:0] fxp_mul(input logic signed [DW-1:0] a,
                                                      input logic signed [DW-1:0] b);
    logic signed [ACC_W-1:0] p;
    p = a * b;
    return p >>> FRAC;
  endfunction

  function automatic logic signed [DW-1:0] sat_dw(input logic signed [ACC_W-1:0] v);
    if (v > ACC_POS) return SAT_POS;
    if (v < ACC_NEG) return SAT_NEG;
    return v[DW-1:0];
  endfunction

  function automatic logic signed [DW-1:0] lane_of(input logic [LANES*DW-1:0] w,
                                                   input logic [1:0] l);
    return w[l*DW +: DW];
  endfunction

endpackage

// File: rtl/fxp_div.sv
// Sequential signed restoring divider: one quotient bit per cycle on magnitudes,
// sign applied at the end, truncated toward zero and saturated to DW bits.
module fxp_div
  import omp_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic signed [NUM_W-1:0] dividend,
  input  logic signed [DW-1:0]    divisor,
  output logic                    busy,
  output logic                    done,
  output logic signed [DW-1:0]    quotient
);

  // Handshake: start is sampled only while !busy; done pulses one cycle and
  // quotient then holds until the next start.
  logic [NUM_W-1:0] quo_q, quo_d;
  logic [DW:0]      rem_q, rem_d, rem_sh;
  logic [DW-1:0]    dvs_q, dvs_d;
  logic [5:0]       cnt_q, cnt_d;
  logic             busy_q, busy_d, done_q, done_d, neg_q, neg_d;

  always_comb begin
    quo_d  = quo_q;
    rem_d  = rem_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    neg_d  = neg_q;
    done_d = 1'b0;
    rem_sh = {rem_q[DW-1:0], quo_q[NUM_W-1]};
    if (start && !busy_q) begin
      quo_d  = dividend[NUM_W-1] ? NUM_W'(-dividend) : dividend;
      dvs_d  = divisor[DW-1] ? DW'(-divisor) : divisor;
      neg_d  = dividend[NUM_W-1] ^ divisor[DW-1];
      rem_d  = '0;
      cnt_d  = 6'(NUM_W);
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (rem_sh >= {1'b0, dvs_q}) begin
        rem_d = rem_sh - {1'b0, dvs_q};
        quo_d = {quo_q[NUM_W-2:0], 1'b1};
      end else begin
        rem_d = rem_sh;
        quo_d = {quo_q[NUM_W-2:0], 1'b0};
      end
      cnt_d = cnt_q - 6'd1;
      if (cnt_q == 6'd1) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      neg_q  <= 1'b0;
    end else begin
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
      neg_q  <= neg_d;
    end
  end

  always_comb begin
    if (!neg_q) quotient = (quo_q > MAG_POS) ? SAT_POS : quo_q[DW-1:0];
    else        quotient = (quo_q > MAG_NEG) ? SAT_NEG : DW'(~quo_q[DW-1:0] + 1'b1);
  end

  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: rtl/omp_estimate_c.sv
// OMP block C: b = Q^T*y over the support, back-substitution U*x = b, then a
// 64-pixel image stream with x_k placed at pixel lambda[k].
module omp_estimate_c
  import omp_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_c,
  input  logic [4:0]            K_final,
  input  logic [2:0]            M_limit,
  input  logic [5:0]            lambda_in,
  input  logic [3:0]            lambda_idx,
  input  logic                  lambda_we,
  output logic [6:0]            q_addr,
  input  logic [LANES*DW-1:0]   q_rdata,
  output logic [2:0]            y_addr,
  input  logic [LANES*DW-1:0]   y_data,
  output logic [5:0]            u_addr,
  input  logic [LANES*DW-1:0]   u_rdata,
  output logic [5:0]            pixel_addr,
  output logic signed [DW-1:0]  pixel_val,
  output logic                  pixel_we,
  output logic                  block_c_done
);

  state_e                  state_q, state_d;
  logic [4:0]              k_lim_q, k_lim_d;
  logic [2:0]              m_lim_q, m_lim_d;
  logic [3:0]              k_q, k_d, i_q, i_d, j_q, j_d;
  logic [2:0]              m_q, m_d;
  logic [1:0]              ph_q, ph_d;
  logic [5:0]              p_q, p_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [5:0]              lam_q [K_MAX];
  logic [5:0]              lam_d [K_MAX];
  logic signed [DW-1:0]    b_q [K_MAX];
  logic signed [DW-1:0]    b_d [K_MAX];
  logic signed [DW-1:0]    x_q [K_MAX];
  logic signed [DW-1:0]    x_d [K_MAX];

  logic signed [ACC_W-1:0] proj_sum, b_ext;
  logic signed [DW-1:0]    u_elem, num, div_q;
  logic signed [NUM_W-1:0] div_num;
  logic                    div_start, div_done, div_busy, bsub_next;
  logic [4:0]              k_clamp;

  fxp_div u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (div_num),
    .divisor  (u_elem),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_q)
  );

  always_comb begin
    state_d   = state_q;
    k_lim_d   = k_lim_q;
    m_lim_d   = m_lim_q;
    k_d       = k_q;
    i_d       = i_q;
    j_d       = j_q;
    m_d       = m_q;
    ph_d      = ph_q;
    p_d       = p_q;
    acc_d     = acc_q;
    lam_d     = lam_q;
    b_d       = b_q;
    x_d       = x_q;
    div_start = 1'b0;
    bsub_next = 1'b0;
    k_clamp   = (K_final > 5'd16) ? 5'd16 : K_final;

    proj_sum = acc_q;
    for (int l = 0; l < LANES; l++)
      proj_sum = proj_sum + fxp_mul(lane_of(q_rdata, 2'(l)), lane_of(y_data, 2'(l)));
    u_elem  = lane_of(u_rdata, i_q[1:0]);
    b_ext   = b_q[i_q];
    num     = sat_dw(b_ext - acc_q);
    div_num = {num, {FRAC{1'b0}}};

    case (state_q)
      ST_IDLE: begin
        if (lambda_we) lam_d[lambda_idx] = lambda_in;
        if (start_c) begin
          k_lim_d = k_clamp;
          m_lim_d = M_limit;
          k_d     = '0;
          m_d     = '0;
          ph_d    = '0;
          acc_d   = '0;
          p_d     = '0;
          state_d = (k_clamp == 5'd0) ? ST_PIXEL : ST_PROJ;
        end
      end
      // Each BRAM read takes an issue cycle (ph 0) and a consume cycle (ph 1).
      ST_PROJ: begin
        if (ph_q == 2'd0) begin
          ph_d = 2'd1;
        end else begin
          ph_d = 2'd0;
          if (m_q == m_lim_q) begin
            b_d[k_q] = sat_dw(proj_sum);
            acc_d    = '0;
            m_d      = '0;
            if ({1'b0, k_q} == 5'(k_lim_q - 5'd1)) begin
              state_d = ST_BSUB;
              i_d     = k_q;
              j_d     = k_q;
            end else begin
              k_d = k_q + 4'd1;
            end
          end else begin
            acc_d = proj_sum;
            m_d   = m_q + 3'd1;
          end
        end
      end
      // Off-diagonal terms are walked from j = K-1 down; the diagonal comes last.
      ST_BSUB: begin
        case (ph_q)
          2'd0: ph_d = 2'd1;
          2'd1: begin
            if (j_q != i_q) begin
              acc_d = acc_q + fxp_mul(u_elem, x_q[j_q]);
              j_d   = j_q - 4'd1;
              ph_d  = 2'd0;
            end else if (u_elem == '0) begin
              x_d[i_q]  = '0;
              bsub_next = 1'b1;
            end else begin
              div_start = 1'b1;
              ph_d      = 2'd2;
            end
          end
          default: begin
            if (div_done) begin
              x_d[i_q]  = div_q;
              bsub_next = 1'b1;
            end
          end
        endcase
        if (bsub_next) begin
          acc_d = '0;
          ph_d  = 2'd0;
          if (i_q == 4'd0) begin
            state_d = ST_PIXEL;
            p_d     = '0;
          end else begin
            i_d = i_q - 4'd1;
            j_d = 4'(k_lim_q - 5'd1);
          end
        end
      end
      ST_PIXEL: begin
        p_d = p_q + 6'd1;
        if (p_q == 6'(N_PIX - 1)) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      k_lim_q <= '0;
      m_lim_q <= '0;
      k_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
      m_q     <= '0;
      ph_q    <= '0;
      p_q     <= '0;
      acc_q   <= '0;
      for (int n = 0; n < K_MAX; n++) begin
        lam_q[n] <= '0;
        b_q[n]   <= '0;
        x_q[n]   <= '0;
      end
    end else begin
      state_q <= state_d;
      k_lim_q <= k_lim_d;
      m_lim_q <= m_lim_d;
      k_q     <= k_d;
      i_q     <= i_d;
      j_q     <= j_d;
      m_q     <= m_d;
      ph_q    <= ph_d;
      p_q     <= p_d;
      acc_q   <= acc_d;
      lam_q   <= lam_d;
      b_q     <= b_d;
      x_q     <= x_d;
    end
  end

  // Scanning from the top slot down lets the lowest matching k win.
  always_comb begin
    pixel_val = '0;
    if (state_q == ST_PIXEL) begin
      for (int n = K_MAX - 1; n >= 0; n--)
        if (n < int'(k_lim_q) && lam_q[n] == p_q) pixel_val = x_q[n];
    end
  end

  assign q_addr       = (state_q == ST_PROJ)  ? {k_q, m_q} : '0;
  assign y_addr       = (state_q == ST_PROJ)  ? m_q : '0;
  assign u_addr       = (state_q == ST_BSUB)  ? {j_q, i_q[3:2]} : '0;
  assign pixel_we     = (state_q == ST_PIXEL);
  assign pixel_addr   = (state_q == ST_PIXEL) ? p_q : '0;
  assign block_c_done = (state_q == ST_DONE);

endmodule

// File: tb/tb_omp_estimate_c.sv
// Bench for omp_estimate_c: BRAM models, a matrix-level reference model and a
// pixel scoreboard.
module tb_omp_estimate_c;

  logic         clk, rst_n, start_c, lambda_we, pixel_we, block_c_done;
  logic [4:0]   K_final;
  logic [2:0]   M_limit, y_addr;
  logic [5:0]   lambda_in, u_addr, pixel_addr;
  logic [3:0]   lambda_idx;
  logic [6:0]   q_addr;
  logic [95:0]  q_rdata, y_data, u_rdata;
  logic [23:0]  pixel_val;

  logic [95:0]  q_mem [128];
  logic [95:0]  y_mem [8];
  logic [95:0]  u_mem [64];

  longint       qm [32][16];
  longint       ym [32];
  longint       um [16][16];
  int           lam_m [16];
  logic [23:0]  cap_val [64];
  logic [31:0]  exp_q [$];
  int           n_vec, n_err, done_cnt;

  omp_estimate_c dut (
    .clk(clk), .rst_n(rst_n), .start_c(start_c), .K_final(K_final), .M_limit(M_limit),
    .lambda_in(lambda_in), .lambda_idx(lambda_idx), .lambda_we(lambda_we),
    .q_addr(q_addr), .q_rdata(q_rdata), .y_addr(y_addr), .y_data(y_data),
    .u_addr(u_addr), .u_rdata(u_rdata), .pixel_addr(pixel_addr), .pixel_val(pixel_val),
    .pixel_we(pixel_we), .block_c_done(block_c_done)
  );

  // clock and BRAM models
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    q_rdata <= q_mem[q_addr];
    y_data  <= y_mem[y_addr];
    u_rdata <= u_mem[u_addr];
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (pixel_we) begin
        cap_val[pixel_addr] = pixel_val;
        if (exp_q.size() == 0) check_eq("extra_pixel", 32'(pixel_we), 32'd0);
        else check_eq("pixel", {2'b0, pixel_addr, pixel_val}, exp_q.pop_front());
      end
      if (block_c_done) begin
        done_cnt++;
        check_eq("done_all_pixels", 32'(exp_q.size()), 32'd0);
        check_eq("done_we_low", 32'(pixel_we), 32'd0);
      end
    end
  end

  // reference model
  function automatic longint sat(input longint v);
    if (v > 64'sd8388607) return 64'sd8388607;
    if (v < -64'sd8388608) return -64'sd8388608;
    return v;
  endfunction

  function automatic longint mshift(input longint a, input longint b);
    return (a * b) >>> 13;
  endfunction

  task automatic model_frame(input int kf, input int ml);
    longint b [16];
    longint x [16];
    longint img [64];
    bit     hit [64];
    longint acc, num;
    int     kk;
    kk = (kf > 16) ? 16 : kf;
    for (int k = 0; k < kk; k++) begin
      acc = 0;
      for (int m = 0; m < 4 * (ml + 1); m++) acc += mshift(qm[m][k], ym[m]);
      b[k] = sat(acc);
    end
    for (int i = kk - 1; i >= 0; i--) begin
      acc = 0;
      for (int j = i + 1; j < kk; j++) acc += mshift(um[i][j], x[j]);
      num = sat(b[i] - acc);
      x[i] = (um[i][i] == 0) ? 0 : sat((num * 8192) / um[i][i]);
    end
    for (int p = 0; p < 64; p++) begin
      img[p] = 0;
      hit[p] = 1'b0;
    end
    for (int k = 0; k < kk; k++)
      if (!hit[lam_m[k]]) begin
        hit[lam_m[k]] = 1'b1;
        img[lam_m[k]] = x[k];
      end
    for (int p = 0; p < 64; p++) exp_q.push_back({2'b0, 6'(p), 24'(img[p])});
  endtask

  task automatic load_mems();
    for (int k = 0; k < 16; k++)
      for (int w = 0; w < 8; w++)
        for (int l = 0; l < 4; l++) q_mem[k*8+w][l*24 +: 24] = 24'(qm[4*w+l][k]);
    for (int w = 0; w < 8; w++)
      for (int l = 0; l < 4; l++) y_mem[w][l*24 +: 24] = 24'(ym[4*w+l]);
    for (int j = 0; j < 16; j++)
      for (int ib = 0; ib < 4; ib++)
        for (int l = 0; l < 4; l++) u_mem[j*4+ib][l*24 +: 24] = 24'(um[ib*4+l][j]);
  endtask

  function automatic longint rnd(input int mag);
    return longint'($urandom_range(0, 2 * mag)) - longint'(mag);
  endfunction

  task automatic clear_mats();
    for (int m = 0; m < 32; m++) begin
      ym[m] = 0;
      for (int k = 0; k < 16; k++) qm[m][k] = 0;
    end
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++) um[i][j] = 0;
  endtask

  task automatic rand_mats();
    int sel;
    for (int m = 0; m < 32; m++) begin
      ym[m] = rnd(16384);
      for (int k = 0; k < 16; k++) qm[m][k] = rnd(16384);
    end
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++) um[i][j] = rnd(16384);
    for (int i = 0; i < 16; i++) begin
      sel = $urandom_range(0, 5);
      if (sel == 0)      um[i][i] = 0;
      else if (sel == 1) um[i][i] = rnd(64);
      else               um[i][i] = ($urandom_range(0, 1) ? 1 : -1) * longint'($urandom_range(4096, 16384));
    end
  endtask

  // driver tasks
  task automatic write_lambda(input int idx, input int val);
    @(posedge clk); #1;
    lambda_we = 1'b1; lambda_idx = 4'(idx); lambda_in = 6'(val);
    @(posedge clk); #1;
    lambda_we = 1'b0;
    lam_m[idx] = val;
  endtask

  task automatic rand_lambdas();
    for (int s = 0; s < 16; s++)
      write_lambda(s, $urandom_range(0, 1) ? $urandom_range(0, 63) : $urandom_range(0, 7));
  endtask

  task automatic run_frame(input int kf, input int ml, input bit poke);
    int kk, lat, bound, d0;
    bit got;
    kk = (kf > 16) ? 16 : kf;
    model_frame(kf, ml);
    load_mems();
    d0 = done_cnt;
    bound = kk * (ml + 1) * 2 + kk * kk * 2 + kk * (24 + 13 + 4) + 70;
    @(posedge clk); #1;
    start_c = 1'b1; K_final = 5'(kf); M_limit = 3'(ml);
    @(posedge clk); #1;
    start_c = 1'b0;
    lat = 1;
    got = 1'b0;
    while (!got && lat < bound + 100) begin
      if (poke && lat == 6) begin
        start_c = 1'b1; lambda_we = 1'b1; lambda_idx = 4'd0; lambda_in = 6'd63;
      end
      if (poke && lat == 7) begin
        start_c = 1'b0; lambda_we = 1'b0;
      end
      @(negedge clk);
      if (block_c_done) got = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    check_eq("done_seen", 32'(got), 32'd1);
    check_eq("latency_bound", 32'(lat <= bound), 32'd1);
    check_eq("frame_complete", 32'(exp_q.size()), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("one_done_pulse", 32'(done_cnt - d0), 32'd1);
    exp_q.delete();
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_we"},   32'(pixel_we), 32'd0);
    check_eq({tag, "_val"},  32'(pixel_val), 32'd0);
    check_eq({tag, "_addr"}, 32'(pixel_addr), 32'd0);
    check_eq({tag, "_done"}, 32'(block_c_done), 32'd0);
    check_eq({tag, "_qa"},   32'(q_addr), 32'd0);
    check_eq({tag, "_ua"},   32'(u_addr), 32'd0);
  endtask

  initial begin
    int d0, kf, ml;
    bit found;
    n_vec = 0; n_err = 0; done_cnt = 0;
    rst_n = 1'b0; start_c = 1'b0; K_final = '0; M_limit = '0;
    lambda_in = '0; lambda_idx = '0; lambda_we = 1'b0;
    for (int s = 0; s < 16; s++) lam_m[s] = 0;
    clear_mats();
    load_mems();
    #1;
    check_outputs_zero("reset");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // nominal three-column case
    clear_mats();
    ym[0] = 8192;
    qm[0][0] = 9 * 8192; qm[0][1] = 16 * 8192; qm[0][2] = 8 * 8192;
    um[0][0] = 16384;
    um[0][1] = 8192; um[1][1] = 3 * 8192;
    um[0][2] = 8192; um[1][2] = 16384; um[2][2] = 4 * 8192;
    write_lambda(0, 4); write_lambda(1, 10); write_lambda(2, 39);
    run_frame(3, 0, 1'b0);
    check_eq("nom_px4",  32'(cap_val[4]),  32'h003000);
    check_eq("nom_px10", 32'(cap_val[10]), 32'h008000);
    check_eq("nom_px39", 32'(cap_val[39]), 32'h004000);
    check_eq("nom_px0",  32'(cap_val[0]),  32'h000000);

    // empty support
    run_frame(0, 3, 1'b0);

    // all eight y words accumulated
    clear_mats();
    for (int m = 0; m < 32; m++) ym[m] = 8192;
    for (int w = 0; w < 8; w++) qm[4*w][0] = 8192;
    um[0][0] = 8192;
    write_lambda(0, 0);
    run_frame(1, 7, 1'b0);
    check_eq("m7_px0", 32'(cap_val[0]), 32'h010000);

    // zero pivot
    rand_mats();
    um[0][0] = 0;
    write_lambda(0, 5);
    run_frame(1, 2, 1'b0);
    check_eq("zero_pivot_px5", 32'(cap_val[5]), 32'h0);

    // randomized frames, one with start/lambda pokes while busy
    for (int t = 0; t < 10; t++) begin
      rand_mats();
      rand_lambdas();
      run_frame($urandom_range(0, 20), $urandom_range(0, 7), t == 2 || t == 5);
    end

    // reset during PIXEL
    rand_mats();
    rand_lambdas();
    kf = 6; ml = 2;
    model_frame(kf, ml);
    load_mems();
    d0 = done_cnt;
    @(posedge clk); #1;
    start_c = 1'b1; K_final = 5'(kf); M_limit = 3'(ml);
    @(posedge clk); #1;
    start_c = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 6000 && !found; c++) begin
      @(negedge clk);
      if (pixel_we && pixel_addr == 6'd20) found = 1'b1;
    end
    check_eq("abort_reached_pixel", 32'(found), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("abort");
    exp_q.delete();
    repeat (3) begin
      @(negedge clk);
      check_eq("abort_hold_we", 32'(pixel_we), 32'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int s = 0; s < 16; s++) lam_m[s] = 0;
    repeat (5) @(negedge clk);
    check_eq("no_done_after_abort", 32'(done_cnt - d0), 32'd0);

    // lambdas were cleared by reset: both slots point at pixel 0, slot 0 wins
    run_frame(2, ml, 1'b0);
    rand_lambdas();
    run_frame(kf, ml, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
